// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the packet-locked FIFO write arbiter.
package fifo_arb_pkg;

  typedef enum logic [0:0] {
    StIdle,
    StLocked
  } arb_state_e;

  // Grant index width; a single requester still gets a 1-bit index.
  function automatic int unsigned gidx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_write_arbiter_if.sv
// Write side of a FIFO: the arbiter drives data/enable, the FIFO reports fill level.
interface fifo_write_interface #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_en;
  logic                  full;
  logic                  almost_full;

  modport master (
    output wr_data,
    output wr_en,
    input  full,
    input  almost_full
  );

  modport slave (
    input  wr_data,
    input  wr_en,
    output full,
    output almost_full
  );
endinterface

// File: rtl/fifo_write_arbiter_rr_pick.sv
// Combinational cyclic priority encoder: first set request at or after start_i.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned GIDX_W = gidx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [GIDX_W-1:0]  start_i,
  output logic [GIDX_W-1:0]  idx_o,
  output logic               any_o
);

  always_comb begin
    logic [GIDX_W:0] pos;
    pos   = '0;
    idx_o = '0;
    any_o = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      // start_i < NUM_REQ, so one subtraction is enough to wrap.
      pos = {1'b0, start_i} + (GIDX_W + 1)'(i);
      if (pos >= (GIDX_W + 1)'(NUM_REQ)) begin
        pos = pos - (GIDX_W + 1)'(NUM_REQ);
      end
      if (!any_o && req_i[pos[GIDX_W-1:0]]) begin
        any_o = 1'b1;
        idx_o = pos[GIDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin, packet-locked arbiter sharing one FIFO write port among NUM_REQ requesters.
module fifo_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_REQ    = 4,
  localparam int unsigned GIDX_W    = gidx_w(NUM_REQ)
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [NUM_REQ-1:0]                  req_valid_i,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  req_data_i,
  input  logic [NUM_REQ-1:0]                  req_last_i,
  output logic [NUM_REQ-1:0]                  req_ready_o,
  fifo_write_interface.master                 fifo,
  output logic                                busy_o,
  output logic [GIDX_W-1:0]                   grant_id_o,
  output logic [31:0]                         words_written_o
);

  arb_state_e              state_q, state_d;
  logic [GIDX_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [GIDX_W-1:0]       grant_q, grant_d;
  logic                    wr_en_q, wr_en_d;
  logic [DATA_WIDTH-1:0]   wr_data_q, wr_data_d;
  logic [31:0]             cnt_q, cnt_d;

  logic [GIDX_W-1:0]       pick_idx;
  logic                    pick_any;
  logic                    space_ok;
  logic                    accept;
  logic [GIDX_W:0]         grant_inc;
  logic [GIDX_W-1:0]       rr_next;

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_pick (
    .req_i   (req_valid_i),
    .start_i (rr_ptr_q),
    .idx_o   (pick_idx),
    .any_o   (pick_any)
  );

  // The word written this cycle is not yet visible in full/almost_full.
  assign space_ok = !fifo.full && !(fifo.almost_full && wr_en_q);
  assign accept   = (state_q == StLocked) && space_ok && req_valid_i[grant_q];

  assign grant_inc = {1'b0, grant_q} + (GIDX_W + 1)'(1);
  assign rr_next   = (grant_inc >= (GIDX_W + 1)'(NUM_REQ)) ? '0 : grant_inc[GIDX_W-1:0];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (pick_any) state_d = StLocked;
      StLocked: if (accept && req_last_i[grant_q]) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    req_ready_o = '0;
    busy_o      = 1'b0;
    if (state_q == StLocked) begin
      busy_o               = 1'b1;
      req_ready_o[grant_q] = space_ok;
    end
  end

  always_comb begin
    grant_d   = grant_q;
    rr_ptr_d  = rr_ptr_q;
    wr_en_d   = accept;
    wr_data_d = accept ? req_data_i[grant_q] : wr_data_q;
    cnt_d     = wr_en_q ? cnt_q + 32'd1 : cnt_q;
    if (state_q == StIdle && pick_any) begin
      grant_d = pick_idx;
    end
    if (accept && req_last_i[grant_q]) begin
      rr_ptr_d = rr_next;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr_q  <= '0;
      grant_q   <= '0;
      wr_en_q   <= 1'b0;
      wr_data_q <= '0;
      cnt_q     <= '0;
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      grant_q   <= grant_d;
      wr_en_q   <= wr_en_d;
      wr_data_q <= wr_data_d;
      cnt_q     <= cnt_d;
    end
  end

  assign fifo.wr_en      = wr_en_q;
  assign fifo.wr_data    = wr_data_q;
  assign grant_id_o      = grant_q;
  assign words_written_o = cnt_q;

  a_no_write_when_full: assert property (@(posedge clk_i) disable iff (rst_i)
    !(wr_en_q && fifo.full));

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Bench for fifo_write_arbiter: cycle table, directed corner sequences, randomized scoreboard run.
module tb_fifo_write_arbiter;
  localparam int N  = 4;
  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst;
  logic [N-1:0]         req_valid, req_last, req_ready;
  logic [N-1:0][DW-1:0] req_data;
  logic                 busy;
  logic [1:0]           grant_id;
  logic [31:0]          words_written;

  fifo_write_interface #(.DATA_WIDTH(DW)) fif ();

  // FIFO model: occupancy counter, flags reflect writes up to the previous edge.
  int   depth = 1000;
  int   fcnt  = 0;
  logic drain = 1'b0;
  logic fclr  = 1'b0;
  assign fif.full        = (fcnt >= depth);
  assign fif.almost_full = (fcnt >= depth - 1);

  fifo_write_arbiter #(
    .DATA_WIDTH (DW),
    .NUM_REQ    (N)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .req_valid_i     (req_valid),
    .req_data_i      (req_data),
    .req_last_i      (req_last),
    .req_ready_o     (req_ready),
    .fifo            (fif),
    .busy_o          (busy),
    .grant_id_o      (grant_id),
    .words_written_o (words_written)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] d;
    logic        l;
  } word_t;

  word_t       pq[N][$];
  logic [31:0] exp_q[N][$];
  logic [N-1:0] gate = '1;
  int          seq = 0;

  logic [31:0] wlog_d[$];
  int          wlog_c[$];
  int          cyc = 0;
  logic        sb_en = 1'b0;
  logic        in_pkt = 1'b0;
  int          cur_id = 0;

  // Word encoding: [31:28] requester, [27] last flag, [26:0] global sequence.
  function automatic logic [31:0] mkword(input int id, input logic last, input int s);
    return {4'(id), last, 27'(s)};
  endfunction

  task automatic push_pkt(input int id, input int len);
    for (int k = 0; k < len; k++) begin
      word_t w;
      w.l = (k == len - 1);
      w.d = mkword(id, w.l, seq);
      seq++;
      pq[id].push_back(w);
      exp_q[id].push_back(w.d);
    end
  endtask

  function automatic int exp_left();
    int s = 0;
    for (int i = 0; i < N; i++) s += exp_q[i].size();
    return s;
  endfunction

  function automatic bit all_empty();
    for (int i = 0; i < N; i++) if (pq[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic sb_word(input logic [31:0] d);
    int id;
    id = int'(d[31:28]);
    if (id >= N) begin
      chk("sb_valid_id", id, 0);
      return;
    end
    if (in_pkt) chk("sb_no_interleave", id, cur_id);
    chk("sb_word_present", exp_q[id].size() > 0, 1);
    if (exp_q[id].size() > 0) begin
      chk("sb_word_order", d, exp_q[id][0]);
      void'(exp_q[id].pop_front());
    end
    in_pkt = !d[27];
    cur_id = id;
  endtask

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fif.wr_en === 1'b1) begin
      chk("no_write_when_full", fcnt < depth, 1);
      wlog_d.push_back(fif.wr_data);
      wlog_c.push_back(cyc);
      if (sb_en) sb_word(fif.wr_data);
    end
    if (fclr) fcnt <= 0;
    else fcnt <= fcnt + ((fif.wr_en === 1'b1) ? 1 : 0) - ((drain && fcnt > 0) ? 1 : 0);
  end

  task automatic step();
    logic [N-1:0] hs;
    for (int i = 0; i < N; i++) begin
      if (pq[i].size() > 0 && gate[i]) begin
        req_valid[i] = 1'b1;
        req_data[i]  = pq[i][0].d;
        req_last[i]  = pq[i][0].l;
      end else begin
        req_valid[i] = 1'b0;
        req_last[i]  = 1'b0;
      end
    end
    @(negedge clk);
    hs = req_valid & req_ready;
    chk("ready_onehot0", $onehot0(req_ready), 1);
    for (int i = 0; i < N; i++) if (hs[i]) void'(pq[i].pop_front());
    @(posedge clk);
    #1;
  endtask

  task automatic run_until_empty(input string nm, input int budget);
    int k = 0;
    while (!all_empty() && k < budget) begin
      step();
      k++;
    end
    chk(nm, all_empty(), 1);
    repeat (4) step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    fclr = 1'b1;
    req_valid = '0;
    req_last = '0;
    req_data = '0;
    gate = '1;
    for (int i = 0; i < N; i++) begin
      pq[i].delete();
      exp_q[i].delete();
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    fclr = 1'b0;
    wlog_d.delete();
    wlog_c.delete();
    in_pkt = 1'b0;
  endtask

  typedef struct {
    logic [3:0]  v;
    logic [3:0]  l;
    logic [23:0] d;
    logic [3:0]  e_rdy;
    logic        e_busy;
    logic [1:0]  e_gid;
    logic        e_wen;
    logic [31:0] e_wd;
    logic [31:0] e_ww;
  } vec_t;

  vec_t tbl[9];

  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin
    // Req 2 sends A,B,C; then everyone offers single-word packets from rr_ptr=3.
    tbl[0] = '{4'b0100, 4'b0000, 24'hA, 4'b0000, 1'b0, 2'd0, 1'b0, 32'h0, 32'd0};
    tbl[1] = '{4'b0100, 4'b0000, 24'hA, 4'b0100, 1'b1, 2'd2, 1'b0, 32'h0, 32'd0};
    tbl[2] = '{4'b0100, 4'b0000, 24'hB, 4'b0100, 1'b1, 2'd2, 1'b1, 32'h0200000A, 32'd0};
    tbl[3] = '{4'b0100, 4'b0100, 24'hC, 4'b0100, 1'b1, 2'd2, 1'b1, 32'h0200000B, 32'd1};
    tbl[4] = '{4'b0000, 4'b0000, 24'hC, 4'b0000, 1'b0, 2'd2, 1'b1, 32'h0200000C, 32'd2};
    tbl[5] = '{4'b1111, 4'b1111, 24'hD, 4'b0000, 1'b0, 2'd2, 1'b0, 32'h0200000C, 32'd3};
    tbl[6] = '{4'b1111, 4'b1111, 24'hD, 4'b1000, 1'b1, 2'd3, 1'b0, 32'h0200000C, 32'd3};
    tbl[7] = '{4'b0000, 4'b0000, 24'hD, 4'b0000, 1'b0, 2'd3, 1'b1, 32'h0300000D, 32'd3};
    tbl[8] = '{4'b0000, 4'b0000, 24'hD, 4'b0000, 1'b0, 2'd3, 1'b0, 32'h0300000D, 32'd4};

    rst = 1'b1;
    req_valid = '0;
    req_last = '0;
    req_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", req_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_wr_en", fif.wr_en, 0);
    chk("rst_wr_data", fif.wr_data, 0);
    chk("rst_words", words_written, 0);
    rst = 1'b0;

    for (int r = 0; r < 9; r++) begin
      req_valid = tbl[r].v;
      req_last  = tbl[r].l;
      for (int i = 0; i < N; i++) req_data[i] = {8'(i), tbl[r].d};
      @(negedge clk);
      chk($sformatf("tbl%0d_ready", r), req_ready, tbl[r].e_rdy);
      chk($sformatf("tbl%0d_busy", r), busy, tbl[r].e_busy);
      chk($sformatf("tbl%0d_grant", r), grant_id, tbl[r].e_gid);
      chk($sformatf("tbl%0d_wr_en", r), fif.wr_en, tbl[r].e_wen);
      chk($sformatf("tbl%0d_wr_data", r), fif.wr_data, tbl[r].e_wd);
      chk($sformatf("tbl%0d_words", r), words_written, tbl[r].e_ww);
      @(posedge clk);
      #1;
    end

    // Contention: rr_ptr is back at 0, four 2-word packets offered together.
    wlog_d.delete();
    wlog_c.delete();
    in_pkt = 1'b0;
    sb_en = 1'b1;
    for (int i = 0; i < N; i++) push_pkt(i, 2);
    run_until_empty("cont_drain", 60);
    chk("cont_words", wlog_d.size(), 8);
    if (wlog_d.size() == 8) begin
      for (int k = 0; k < 8; k++) chk($sformatf("cont_order%0d", k), wlog_d[k][31:28], k / 2);
      for (int k = 1; k < 8; k++)
        chk($sformatf("cont_gap%0d", k), wlog_c[k] - wlog_c[k-1], (k % 2 == 1) ? 1 : 2);
    end
    chk("cont_sb_left", exp_left(), 0);
    sb_en = 1'b0;

    // Backpressure: depth 4, never drained.
    depth = 4;
    do_reset();
    push_pkt(0, 6);
    repeat (12) step();
    chk("bp_words", words_written, 4);
    chk("bp_fill", fcnt, 4);
    chk("bp_ready", req_ready, 0);
    chk("bp_busy", busy, 1);
    // One-cycle drain with a competitor waiting: one word only, lock kept.
    push_pkt(1, 1);
    drain = 1'b1;
    step();
    drain = 1'b0;
    repeat (6) step();
    chk("dr_words", words_written, 5);
    chk("dr_grant", grant_id, 0);
    chk("dr_busy", busy, 1);
    chk("dr_left", pq[0].size(), 1);
    drain = 1'b1;
    run_until_empty("dr_finish", 100);
    chk("dr_total", words_written, 7);
    drain = 1'b0;
    depth = 1000;

    // Reset on the 2nd word of a 4-word packet after rr_ptr was moved to 3.
    do_reset();
    push_pkt(2, 1);
    run_until_empty("rm_pre", 20);
    push_pkt(3, 4);
    repeat (3) step();
    chk("rm_two_accepted", pq[3].size(), 2);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rm_ready", req_ready, 0);
    chk("rm_busy", busy, 0);
    chk("rm_grant", grant_id, 0);
    chk("rm_wr_en", fif.wr_en, 0);
    chk("rm_wr_data", fif.wr_data, 0);
    chk("rm_words", words_written, 0);
    rst = 1'b0;
    for (int i = 0; i < N; i++) pq[i].delete();
    push_pkt(3, 1);
    push_pkt(1, 1);
    step();
    chk("rm_fresh_grant", grant_id, 1);
    chk("rm_fresh_busy", busy, 1);
    run_until_empty("rm_post", 20);

    // Randomized traffic against the packet scoreboard, small FIFO, random drain.
    do_reset();
    depth = 5;
    sb_en = 1'b1;
    begin
      int total = 0;
      int k = 0;
      for (int p = 0; p < 60; p++) begin
        int len = $urandom_range(1, 4);
        push_pkt($urandom_range(0, N - 1), len);
        total += len;
      end
      while (!all_empty() && k < 4000) begin
        gate  = 4'($urandom);
        drain = 1'($urandom_range(0, 1));
        step();
        k++;
      end
      chk("rnd_drain", all_empty(), 1);
      gate  = '1;
      drain = 1'b1;
      repeat (8) step();
      chk("rnd_sb_left", exp_left(), 0);
      chk("rnd_words", words_written, total);
    end

    // Counter: 1000 single-word packets.
    do_reset();
    depth = 8;
    drain = 1'b1;
    for (int p = 0; p < 1000; p++) push_pkt($urandom_range(0, N - 1), 1);
    run_until_empty("cnt_drain", 6000);
    chk("cnt_words", words_written, 1000);
    chk("cnt_sb_left", exp_left(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_write_arbiter.md
# fifo_write_arbiter

Shares one FIFO write port among NUM_REQ packet-oriented requesters. Round-robin arbitration with the grant locked for a whole packet, so words from different requesters never interleave in the FIFO. Drives a `fifo_write_interface` master modport through a registered output stage. Uses `full`/`almost_full` to guarantee no write is ever issued into a full FIFO.

## Interface
- DATA_WIDTH, 32, word width; must match the attached FIFO.
- NUM_REQ, 4, number of requesters; legal range 1..16.
- GIDX_W, derived: max(1, $clog2(NUM_REQ)); not user-settable.

- clock  in  1  single clock; all logic rising-edge.
- reset  in  1  synchronous, active-high; sampled on `clock`.
- req_valid  in  NUM_REQ  per-requester word valid.
- req_data  in  NUM_REQ x DATA_WIDTH  per-requester word.
- req_last  in  NUM_REQ  marks the final word of a packet; qualified by req_valid.
- req_ready  out  NUM_REQ  word accepted this cycle when valid & ready; one-hot or zero.
- fifo  master modport  fifo_write_interface #(DATA_WIDTH)  wr_data/wr_en out; full/almost_full in.
- busy  out  1  high while in LOCKED.
- grant_id  out  GIDX_W  index of the current/last granted requester.
- words_written  out  32  count of wr_en cycles since reset; wraps at 2^32.

## Operation
- Requester rules: once req_valid is high, data/last are held stable until accepted. Dropping valid mid-packet is legal; the lock is kept.
- FIFO contract: almost_full is high when at most one slot is free. full/almost_full reflect writes up to and including the previous cycle.
- States:
  - IDLE: if any req_valid, pick the first valid index at or after rr_ptr (cyclic), load grant_id, go to LOCKED. No req_ready in IDLE.
  - LOCKED: req_ready[grant_id] = space_ok. On accept with req_last, go to IDLE and set rr_ptr = (grant_id+1) mod NUM_REQ. Otherwise stay.
- space_ok = !full && !(almost_full && fifo.wr_en). A word is accepted only when at least one slot remains after the in-flight write.
- Output stage: on accept, wr_data <= req_data[grant_id] and wr_en <= 1; otherwise wr_en <= 0 and wr_data holds its value.
- words_written increments each cycle fifo.wr_en is high.
- NUM_REQ=1: rr_ptr is constant 0; same FSM.
- The first requester in a given cycle is not favoured; only rr_ptr sets priority.

## Timing
- Reset values: state IDLE, rr_ptr 0, grant_id 0, req_ready 0, fifo.wr_en 0, fifo.wr_data 0, busy 0, words_written 0.
- Reset mid-packet: everything above is forced in the next cycle and the partial packet is abandoned. Already-written words stay in the FIFO; cleaning them up is the system's job.
- Latency: valid at cycle t (IDLE) -> grant at t+1 -> req_ready at t+1 if space_ok -> wr_en at t+2.
- Throughput: one word per cycle within a packet; one IDLE bubble between packets.
- Single-word packet (valid & last) is accepted in its first LOCKED cycle.
- full high: req_ready 0 and the state is held; resume on the first cycle full drops.
- Invariant (assertion): never fifo.wr_en && full in the same cycle.

## Structure
- Package `fifo_arb_pkg`: state enum (IDLE, LOCKED), GIDX_W helper function.
- Sub-module `rr_pick`: combinational cyclic priority encoder (req vector, start pointer -> index, any). Everything else lives in the top block.

## Test plan
- Single requester: req 2 sends a 3-word packet 0xA,0xB,0xC with an empty FIFO -> wr_en at t+2..t+4 carries A,B,C; rr_ptr becomes 3.
- Contention: all 4 requesters valid, each with 2-word packets, rr_ptr=0 -> grant order 0,1,2,3. Words never interleave; one bubble between packets.
- Backpressure: FIFO depth 4 held undrained -> exactly 4 writes. At the 4th accept, almost_full && wr_en blocks further ready; no wr_en while full.
- Drain mid-packet: full drops for one cycle -> exactly one word accepted; the lock is held to the same requester.
- Reset at the 2nd word of a 4-word packet -> next cycle all outputs at reset values. A new packet from req 1 starts a fresh grant with rr_ptr=0 priority.
- Counter: run 1000 single-word packets -> words_written = 1000.
